// File: rtl/pwm_ramp_sequencer_if.sv
// Target handshake between the register front end and the PWM ramp sequencer.
interface pwm_ramp_sequencer_if #(
   parameter int THRESHOLD_NBITS = 4
);
   logic [THRESHOLD_NBITS-1:0] target;
   logic                       target_valid;
   logic                       target_ready;

   modport master (
      output target,
      output target_valid,
      input  target_ready
   );

   modport slave (
      input  target,
      input  target_valid,
      output target_ready
   );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Ramps the PWM comparator threshold one LSB at a time toward an accepted target,
// stepping only on PWM period boundaries so no period sees a mid-period change.
//
// state     | meaning
// ST_IDLE   | waiting for a target, ready high
// ST_RAMP   | stepping threshold every STEP_PERIODS qualifying ticks
// ST_DONE   | one-cycle completion pulse, then back to idle
module pwm_ramp_sequencer #(
   parameter int THRESHOLD_NBITS = 4,
   parameter int STEP_PERIODS    = 8,
   parameter int INIT_THRESHOLD  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       period_tick,
   pwm_ramp_sequencer_if.slave        tgt_if,
   output logic [THRESHOLD_NBITS-1:0] threshold,
   output logic                       busy,
   output logic                       done
);

   localparam int PCW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [PCW-1:0]             PER_RELOAD = PCW'(STEP_PERIODS - 1);
   localparam logic [THRESHOLD_NBITS-1:0] THR_INIT   = THRESHOLD_NBITS'(INIT_THRESHOLD);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [THRESHOLD_NBITS-1:0] tgt_q, tgt_d;
   logic [THRESHOLD_NBITS-1:0] threshold_q, threshold_d;
   logic [PCW-1:0]             per_cnt_q, per_cnt_d;
   logic [THRESHOLD_NBITS-1:0] stepped;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tgt_q       <= THR_INIT;
         threshold_q <= THR_INIT;
         per_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         threshold_q <= threshold_d;
         per_cnt_q   <= per_cnt_d;
      end
   end

   // per_cnt is a down-counter of periods remaining; a step fires at terminal count 0.
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      threshold_d = threshold_q;
      per_cnt_d   = per_cnt_q;
      stepped     = threshold_q;
      case (state_q)
         ST_IDLE: begin
            per_cnt_d = '0;
            if (tgt_if.target_valid) begin
               tgt_d     = tgt_if.target;
               per_cnt_d = PER_RELOAD;
               state_d   = (tgt_if.target == threshold_q) ? ST_DONE : ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (period_tick && enable) begin
               if (per_cnt_q == '0) begin
                  per_cnt_d   = PER_RELOAD;
                  stepped     = (tgt_q > threshold_q) ? threshold_q + 1'b1
                                                      : threshold_q - 1'b1;
                  threshold_d = stepped;
                  if (stepped == tgt_q) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  per_cnt_d = per_cnt_q - 1'b1;
               end
            end
         end
         ST_DONE: begin
            per_cnt_d = '0;
            state_d   = ST_IDLE;
         end
         default: begin
            per_cnt_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   assign tgt_if.target_ready = (state_q == ST_IDLE);
   assign busy                = (state_q == ST_RAMP);
   assign done                = (state_q == ST_DONE);
   assign threshold           = threshold_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: N=4, STEP_PERIODS=2, tick every 16 cycles.
// A second instance with INIT_THRESHOLD=5 covers mid-ramp reset and endpoints.
module tb_pwm_ramp_sequencer;

   logic       clk;
   logic       rst;
   logic       rst5;
   logic       enable;
   logic       period_tick;
   logic [3:0] thr_a, thr_b;
   logic       busy_a, busy_b;
   logic       done_a, done_b;

   int n_chk;
   int n_err;

   pwm_ramp_sequencer_if #(.THRESHOLD_NBITS(4)) tgt_a ();
   pwm_ramp_sequencer_if #(.THRESHOLD_NBITS(4)) tgt_b ();

   pwm_ramp_sequencer #(
      .THRESHOLD_NBITS (4),
      .STEP_PERIODS    (2),
      .INIT_THRESHOLD  (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .period_tick (period_tick),
      .tgt_if      (tgt_a),
      .threshold   (thr_a),
      .busy        (busy_a),
      .done        (done_a)
   );

   pwm_ramp_sequencer #(
      .THRESHOLD_NBITS (4),
      .STEP_PERIODS    (2),
      .INIT_THRESHOLD  (5)
   ) dut5 (
      .clk         (clk),
      .rst         (rst5),
      .enable      (enable),
      .period_tick (period_tick),
      .tgt_if      (tgt_b),
      .threshold   (thr_b),
      .busy        (busy_b),
      .done        (done_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic gap(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      period_tick = 1'b1;
      @(posedge clk);
      #1;
      period_tick = 1'b0;
   endtask

   task automatic period();
      gap(15);
      tick();
   endtask

   task automatic periods(input int n);
      for (int i = 0; i < n; i++) period();
   endtask

   task automatic send(input int which, input logic [3:0] val);
      if (which == 0) begin
         tgt_a.target       = val;
         tgt_a.target_valid = 1'b1;
      end else begin
         tgt_b.target       = val;
         tgt_b.target_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      tgt_a.target_valid = 1'b0;
      tgt_b.target_valid = 1'b0;
   endtask

   initial begin
      n_chk              = 0;
      n_err              = 0;
      rst                = 1'b1;
      rst5               = 1'b1;
      enable             = 1'b1;
      period_tick        = 1'b0;
      tgt_a.target       = 4'd0;
      tgt_a.target_valid = 1'b0;
      tgt_b.target       = 4'd0;
      tgt_b.target_valid = 1'b0;

      @(posedge clk);
      #1;
      check_eq("rst_thr", thr_a, 0);
      check_eq("rst_ready", tgt_a.target_ready, 1);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_done", done_a, 0);
      check_eq("rst_thr_init5", thr_b, 5);
      #4 rst = 1'b0;
      @(posedge clk);
      #1;

      // async reset in the middle of a cycle, mid-ramp
      send(0, 4'd3);
      periods(2);
      check_eq("pre_rst_thr", thr_a, 1);
      check_eq("pre_rst_busy", busy_a, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_thr", thr_a, 0);
      check_eq("async_rst_busy", busy_a, 0);
      check_eq("async_rst_done", done_a, 0);
      check_eq("async_rst_ready", tgt_a.target_ready, 1);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // ramp up 0 -> 3
      check_eq("up_ready", tgt_a.target_ready, 1);
      send(0, 4'd3);
      check_eq("up_busy_acc", busy_a, 1);
      check_eq("up_ready_acc", tgt_a.target_ready, 0);
      period();
      check_eq("up_t1", thr_a, 0);
      period();
      check_eq("up_t2", thr_a, 1);
      periods(2);
      check_eq("up_t4", thr_a, 2);
      period();
      check_eq("up_t5_thr", thr_a, 2);
      check_eq("up_t5_busy", busy_a, 1);
      check_eq("up_t5_done", done_a, 0);
      period();
      check_eq("up_t6_thr", thr_a, 3);
      check_eq("up_t6_done", done_a, 1);
      check_eq("up_t6_busy", busy_a, 0);
      gap(1);
      check_eq("up_after_done", done_a, 0);
      check_eq("up_after_ready", tgt_a.target_ready, 1);

      // 3 -> 15, then down to 12 with ignored target pulses
      send(0, 4'd15);
      periods(24);
      check_eq("to15_thr", thr_a, 15);
      check_eq("to15_done", done_a, 1);
      gap(1);
      send(0, 4'd12);
      period();
      check_eq("dn_ready_ramp", tgt_a.target_ready, 0);
      send(0, 4'd0);
      period();
      check_eq("dn_t2", thr_a, 14);
      send(0, 4'd0);
      periods(2);
      check_eq("dn_t4", thr_a, 13);
      check_eq("dn_busy", busy_a, 1);
      periods(2);
      check_eq("dn_t6_thr", thr_a, 12);
      check_eq("dn_t6_done", done_a, 1);
      gap(1);

      // idle ticks, then equal target
      periods(3);
      check_eq("idle_tick_thr", thr_a, 12);
      check_eq("idle_tick_ready", tgt_a.target_ready, 1);
      send(0, 4'd12);
      check_eq("eq_done", done_a, 1);
      check_eq("eq_busy", busy_a, 0);
      check_eq("eq_thr", thr_a, 12);
      check_eq("eq_ready", tgt_a.target_ready, 0);
      gap(1);
      check_eq("eq_ready_back", tgt_a.target_ready, 1);
      check_eq("eq_done_low", done_a, 0);

      // enable freeze during 0 -> 3
      send(0, 4'd0);
      periods(24);
      check_eq("to0_thr", thr_a, 0);
      gap(1);
      send(0, 4'd3);
      periods(3);
      check_eq("frz_t3", thr_a, 1);
      enable = 1'b0;
      periods(5);
      check_eq("frz_hold_thr", thr_a, 1);
      check_eq("frz_hold_busy", busy_a, 1);
      enable = 1'b1;
      period();
      check_eq("frz_resume", thr_a, 2);
      period();
      check_eq("frz_resume2", thr_a, 2);
      period();
      check_eq("frz_end_thr", thr_a, 3);
      check_eq("frz_end_done", done_a, 1);
      gap(1);

      // INIT_THRESHOLD=5 instance: reset mid-ramp, endpoints
      #4 rst5 = 1'b0;
      @(posedge clk);
      #1;
      send(1, 4'd15);
      periods(8);
      check_eq("i5_mid_thr", thr_b, 9);
      #2 rst5 = 1'b1;
      #1;
      check_eq("i5_rst_thr", thr_b, 5);
      check_eq("i5_rst_busy", busy_b, 0);
      check_eq("i5_rst_ready", tgt_b.target_ready, 1);
      #2 rst5 = 1'b0;
      @(posedge clk);
      #1;
      send(1, 4'd0);
      periods(9);
      check_eq("i5_to0_pre", thr_b, 1);
      period();
      check_eq("i5_to0_thr", thr_b, 0);
      check_eq("i5_to0_done", done_b, 1);
      gap(1);
      periods(2);
      check_eq("i5_zero_hold", thr_b, 0);
      send(1, 4'd15);
      periods(30);
      check_eq("i5_to15_thr", thr_b, 15);
      check_eq("i5_to15_done", done_b, 1);
      gap(1);
      periods(2);
      check_eq("i5_max_hold", thr_b, 15);
      check_eq("i5_max_ready", tgt_b.target_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
